// File: rtl/bcm_scanout.sv
// bcm_scanout: binary-code-modulation scan-out engine for a HUB75-style LED panel.
// Reads 12-bit pixels from the framebuffer and shifts them out plane by plane,
// lighting each plane for BASE_TICKS << plane cycles.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   enable       start/continue scanning (sampled in IDLE and at frame end)
//   fb_addr      framebuffer read address {row, col}
//   fb_data      framebuffer read data, valid one cycle after fb_addr
//   sdata, sclk  serial pixel bit and shift clock to the panel
//   latch        panel latch strobe
//   oe_n         panel output enable, active low
//   row          panel row select
//   frame_done   one-cycle pulse after the last plane of the last row
module bcm_scanout #(
    parameter int COLS       = 32,
    parameter int ROW_BITS   = 4,
    parameter int BASE_TICKS = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    output logic [ROW_BITS+$clog2(COLS)-1:0] fb_addr,
    input  logic [11:0]                      fb_data,
    output logic                             sdata,
    output logic                             sclk,
    output logic                             latch,
    output logic                             oe_n,
    output logic [ROW_BITS-1:0]              row,
    output logic                             frame_done
);

    localparam int CW  = $clog2(COLS);
    localparam int AW  = ROW_BITS + CW;
    localparam int SCW = $clog2(2 * COLS + 2);
    localparam int SW  = 12 + $clog2(BASE_TICKS);

    localparam logic [SCW-1:0]      SLAST = SCW'(2 * COLS + 1);
    localparam logic [SCW-1:0]      SADDR = SCW'(2 * COLS);
    localparam logic [SW-1:0]       BT    = SW'(BASE_TICKS);
    localparam logic [3:0]          PTOP  = 4'd11;
    localparam logic [ROW_BITS-1:0] RMAX  = {ROW_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH,
        SHOW
    } state_t;

    state_t              state, state_n;
    logic [SCW-1:0]      scnt, scnt_n;
    logic [SW-1:0]       showcnt, show_n;
    logic [3:0]          plane, plane_n;
    logic [ROW_BITS-1:0] row_cnt, rcnt_n;

    logic [AW-1:0]       addr_n;
    logic                sdata_n;
    logic                sclk_n;
    logic                latch_n;
    logic                oe_n_n;
    logic [ROW_BITS-1:0] row_n;
    logic                fd_n;

    // Next-state and counter logic.
    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        show_n  = showcnt;
        plane_n = plane;
        rcnt_n  = row_cnt;
        fd_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = SHIFT;
                    scnt_n  = '0;
                    plane_n = PTOP;
                    rcnt_n  = '0;
                end
            end
            SHIFT: begin
                if (scnt == SLAST) begin
                    state_n = LATCH;
                end else begin
                    scnt_n = scnt + SCW'(1);
                end
            end
            LATCH: begin
                state_n = SHOW;
                // Down-counter: SHOW lasts (BT << plane) cycles.
                show_n  = (BT << plane) - SW'(1);
            end
            SHOW: begin
                if (showcnt != '0) begin
                    show_n = showcnt - SW'(1);
                end else begin
                    scnt_n = '0;
                    if (plane != 4'd0) begin
                        state_n = SHIFT;
                        plane_n = plane - 4'd1;
                    end else begin
                        plane_n = PTOP;
                        if (row_cnt == RMAX) begin
                            rcnt_n  = '0;
                            fd_n    = 1'b1;
                            state_n = enable ? SHIFT : IDLE;
                        end else begin
                            rcnt_n  = row_cnt + ROW_BITS'(1);
                            state_n = SHIFT;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // every panel output can be registered.
    always_comb begin
        addr_n  = fb_addr;
        sdata_n = sdata;
        row_n   = row;
        // Even SHIFT cycles 0..2*COLS-2 issue column s/2.
        if (state_n == SHIFT && !scnt_n[0] && scnt_n < SADDR) begin
            addr_n = {rcnt_n, scnt_n[CW:1]};
        end
        // Data for the column issued one cycle earlier arrives on odd cycles.
        if (state == SHIFT && scnt[0] && scnt != SLAST) begin
            sdata_n = fb_data[plane];
        end
        sclk_n  = (state_n == SHIFT) && scnt_n[0] && (scnt_n >= SCW'(3));
        latch_n = (state_n == LATCH);
        oe_n_n  = (state_n != SHOW);
        if (state_n == LATCH) begin
            row_n = row_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            scnt    <= '0;
            showcnt <= '0;
            plane   <= PTOP;
            row_cnt <= '0;
        end else begin
            state   <= state_n;
            scnt    <= scnt_n;
            showcnt <= show_n;
            plane   <= plane_n;
            row_cnt <= rcnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr    <= '0;
            sdata      <= 1'b0;
            sclk       <= 1'b0;
            latch      <= 1'b0;
            oe_n       <= 1'b1;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            fb_addr    <= addr_n;
            sdata      <= sdata_n;
            sclk       <= sclk_n;
            latch      <= latch_n;
            oe_n       <= oe_n_n;
            row        <= row_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_bcm_scanout.sv
// tb_bcm_scanout: scoreboard bench for bcm_scanout.
// Expected bit stream, row order and lit times are queued per frame and popped by monitors.
module tb_bcm_scanout;

    localparam int COLS = 4;
    localparam int NROW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic [2:0]  fb_addr;
    logic [11:0] fb_data;
    logic        sdata, sclk, latch, oe_n, frame_done;
    logic [0:0]  row;

    logic        en3;
    logic [2:0]  fb_addr3;
    logic [11:0] fb_data3;
    logic        sdata3, sclk3, latch3, oe3, fd3;
    logic [0:0]  row3;

    bcm_scanout #(.COLS(4), .ROW_BITS(1), .BASE_TICKS(1)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fb_addr(fb_addr), .fb_data(fb_data),
        .sdata(sdata), .sclk(sclk), .latch(latch), .oe_n(oe_n),
        .row(row), .frame_done(frame_done)
    );

    bcm_scanout #(.COLS(4), .ROW_BITS(1), .BASE_TICKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(en3),
        .fb_addr(fb_addr3), .fb_data(fb_data3),
        .sdata(sdata3), .sclk(sclk3), .latch(latch3), .oe_n(oe3),
        .row(row3), .frame_done(fd3)
    );

    logic [11:0] mem [8];
    always @(posedge clk) fb_data <= mem[fb_addr];
    assign fb_data3 = 12'hA5A;

    typedef struct {
        int len;
        bit fd;
    } run_t;

    bit   exp_bits[$];
    int   exp_rows[$];
    run_t exp_runs[$];
    int   exp3[$];

    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // Reference: each row shows planes 11..0; each plane shifts columns 0..COLS-1
    // of that plane's bit, then lights for 2^plane ticks.
    task automatic push_frame();
        for (int r = 0; r < NROW; r++) begin
            for (int p = 11; p >= 0; p--) begin
                exp_rows.push_back(r);
                for (int c = 0; c < COLS; c++)
                    exp_bits.push_back(mem[r*COLS+c][p]);
                exp_runs.push_back('{1 << p, (r == NROW-1 && p == 0)});
            end
        end
    endtask

    task automatic clear_q();
        exp_bits.delete();
        exp_rows.delete();
        exp_runs.delete();
    endtask

    task automatic wait_fd(input int n, input int lim);
        int k = 0;
        while (fd_cnt < n && k < lim) begin
            @(posedge clk);
            k++;
        end
        chk("frame_done_seen", int'(fd_cnt >= n), 1);
    endtask

    task automatic idle_check(input int fds);
        logic [2:0] a;
        int bad = 0;
        a = fb_addr;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (!oe_n || sclk || latch || fb_addr != a) bad++;
        end
        chk("idle_quiet", bad, 0);
        chk("no_extra_frame", fd_cnt, fds);
        chk("bits_consumed", exp_bits.size(), 0);
        chk("rows_consumed", exp_rows.size(), 0);
        chk("runs_consumed", exp_runs.size(), 0);
    endtask

    // Main monitor.
    initial begin : mon
        int   run_len, gap, lidx, cyc, rs_stamp, fd_stamp;
        bit   rs_valid, fd_valid, prev_fd, prev_latch, ended;
        run_t rr;
        run_len = 0; gap = -1; lidx = 0; cyc = 0;
        rs_stamp = 0; fd_stamp = 0;
        rs_valid = 0; fd_valid = 0; prev_fd = 0; prev_latch = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                run_len = 0; gap = -1; lidx = 0;
                rs_valid = 0; fd_valid = 0; prev_fd = 0; prev_latch = 0;
            end else begin
                ended = 0;
                if (sclk) begin
                    if (exp_bits.size() == 0) chk("sdata_extra", 1, 0);
                    else chk("sdata", int'(sdata), int'(exp_bits.pop_front()));
                end
                if (latch) begin
                    if (exp_rows.size() == 0) chk("latch_extra", 1, 0);
                    else chk("row", int'(row), exp_rows.pop_front());
                    if (gap >= 0) chk("shift_len", gap, 2*COLS+2);
                    gap = -1;
                    if (lidx % 12 == 0) begin
                        if (rs_valid) chk("row_period", cyc - rs_stamp, 4227);
                        rs_stamp = cyc;
                        rs_valid = 1;
                    end
                    lidx++;
                end else if (gap >= 0) begin
                    gap++;
                end
                if (!oe_n) begin
                    if (run_len == 0) chk("latch_before_show", int'(prev_latch), 1);
                    run_len++;
                end else if (run_len > 0) begin
                    ended = 1;
                    if (exp_runs.size() == 0) begin
                        chk("show_extra", 1, 0);
                    end else begin
                        rr = exp_runs.pop_front();
                        chk("show_len", run_len, rr.len);
                        chk("frame_done_at_end", int'(frame_done), int'(rr.fd));
                    end
                    run_len = 0;
                    gap = 1;
                end
                if (frame_done) begin
                    if (!ended) chk("frame_done_stray", 1, 0);
                    if (prev_fd) chk("frame_done_width", 2, 1);
                    if (fd_valid) chk("frame_period", cyc - fd_stamp, 8454);
                    fd_stamp = cyc;
                    fd_valid = 1;
                    fd_cnt++;
                end
                prev_fd = frame_done;
                prev_latch = latch;
            end
        end
    end

    // Lit-time monitor for the BASE_TICKS=3 instance.
    initial begin : mon3
        int r3;
        r3 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                r3 = 0;
            end else if (!oe3) begin
                r3++;
            end else if (r3 > 0) begin
                if (exp3.size() > 0) chk("show_len_bt3", r3, exp3.pop_front());
                r3 = 0;
            end
        end
    end

    initial begin : stim
        int base;
        rst_n  = 1'b0;
        enable = 1'b1;
        en3    = 1'b1;
        mem[0] = 12'h800;
        mem[1] = 12'h000;
        mem[2] = 12'hFFF;
        mem[3] = 12'h801;
        for (int i = 4; i < 8; i++) mem[i] = 12'($urandom_range(0, 4095));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_sdata", int'(sdata), 0);
        chk("rst_sclk", int'(sclk), 0);
        chk("rst_latch", int'(latch), 0);
        chk("rst_oe_n", int'(oe_n), 1);
        chk("rst_row", int'(row), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        push_frame();
        push_frame();
        for (int p = 11; p >= 0; p--) exp3.push_back(3 << p);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_addr", int'(fb_addr), 0);
        chk("first_oe_n", int'(oe_n), 1);
        @(posedge clk); #1;
        chk("addr_hold_s1", int'(fb_addr), 0);
        @(posedge clk); #1;
        chk("addr_col1", int'(fb_addr), 1);

        wait_fd(1, 9000);
        repeat (2000) @(posedge clk);
        #1 enable = 1'b0;
        wait_fd(2, 9000);
        idle_check(2);
        chk("bt3_runs_done", exp3.size(), 0);

        // Second pass: fresh random frame, reset mid-SHOW, restart.
        @(posedge clk); #1;
        rst_n = 1'b0;
        en3 = 1'b0;
        clear_q();
        for (int i = 0; i < 8; i++) mem[i] = 12'($urandom_range(0, 4095));
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_frame();
        enable = 1'b1;
        repeat ($urandom_range(2200, 2900)) @(posedge clk);
        #1 chk("pre_reset_show", int'(oe_n), 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_oe_n", int'(oe_n), 1);
        chk("async_latch", int'(latch), 0);
        chk("async_sclk", int'(sclk), 0);
        chk("async_row", int'(row), 0);
        chk("async_fb_addr", int'(fb_addr), 0);
        clear_q();
        push_frame();
        push_frame();
        base = fd_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fd(base + 1, 9000);
        repeat (1000) @(posedge clk);
        #1 enable = 1'b0;
        wait_fd(base + 2, 9000);
        idle_check(base + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
